// File: rtl/counter_sequencer.sv
// Wishbone-programmable up-counter sequencer: start/stop, load, compare-match,
// auto-reload/one-shot, level IRQ and LA load arbitration.
// Optional 8-bit tick prescaler (register 5) is built when COUNTER_SEQ_PRESCALER_EN is defined.
module counter_sequencer #(
  parameter int BITS = 16
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_ni,
  input  logic            wbs_stb_i,
  input  logic            wbs_cyc_i,
  input  logic            wbs_we_i,
  input  logic [3:0]      wbs_sel_i,
  input  logic [31:0]     wbs_dat_i,
  input  logic [31:0]     wbs_adr_i,
  output logic            wbs_ack_o,
  output logic [31:0]     wbs_dat_o,
  input  logic            la_load_i,
  input  logic [BITS-1:0] la_value_i,
  output logic            la_busy_o,
  output logic [BITS-1:0] count_o,
  output logic            running_o,
  output logic            irq_o
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  localparam logic [2:0] A_CTRL   = 3'd0;
  localparam logic [2:0] A_LOAD   = 3'd1;
  localparam logic [2:0] A_CMP    = 3'd2;
  localparam logic [2:0] A_STATUS = 3'd3;
  localparam logic [2:0] A_COUNT  = 3'd4;
  localparam logic [2:0] A_PRESC  = 3'd5;

  logic [1:0]      state, state_nxt;
  logic            ctrl_en, ctrl_oneshot, ctrl_irq_en;
  logic [BITS-1:0] load_val, cmp_val, count;
  logic            match_flag;
  logic            la_pending;
  logic [BITS-1:0] la_value_q;

  logic [2:0]  reg_sel;
  logic [31:0] byte_mask;
  logic        wb_req, wr_req, rd_req;
  logic        wr_ctrl, wb_load, en_nxt;
  logic        la_take, load_any, tick, at_cmp, presc_done;
  logic [BITS-1:0] la_load_val;
  logic [31:0] rd_data;

  // Address bits outside [4:2] are deliberately ignored.
  logic unused_adr;
  assign unused_adr = ^{wbs_adr_i[31:5], wbs_adr_i[1:0]};

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [31:0] mask);
    return (old_v & ~mask) | (new_v & mask);
  endfunction

  assign reg_sel   = wbs_adr_i[4:2];
  assign byte_mask = {{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}}, {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};
  assign wb_req    = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o;
  assign wr_req    = wb_req & wbs_we_i;
  assign rd_req    = wb_req & ~wbs_we_i;

  // EN as it will be after this cycle's write, so a same-cycle EN clear steers the FSM at once.
  assign wr_ctrl = wr_req && (reg_sel == A_CTRL) && wbs_sel_i[0];
  assign wb_load = wr_ctrl & wbs_dat_i[3];
  assign en_nxt  = wr_ctrl ? wbs_dat_i[0] : ctrl_en;

  // WB load wins; a losing or pending LA request is applied on the first free cycle.
  assign la_take     = (la_load_i | la_pending) & ~wb_load;
  assign la_load_val = la_load_i ? la_value_i : la_value_q;
  assign load_any    = wb_load | la_take;
  assign tick        = (state == ST_RUN) & ~load_any & presc_done;
  assign at_cmp      = (count == cmp_val);

  // NOTE: combinational blocks assign a default first so every path is covered and no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (en_nxt) state_nxt = ST_RUN;
      ST_RUN: begin
        if (!en_nxt)                            state_nxt = ST_IDLE;
        else if (tick && at_cmp && ctrl_oneshot) state_nxt = ST_HOLD;
      end
      ST_HOLD: begin
        if (!en_nxt)      state_nxt = ST_IDLE;
        else if (wb_load) state_nxt = ST_RUN;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state        <= ST_IDLE;
      ctrl_en      <= 1'b0;
      ctrl_oneshot <= 1'b0;
      ctrl_irq_en  <= 1'b0;
      load_val     <= '0;
      cmp_val      <= '0;
      count        <= '0;
      match_flag   <= 1'b0;
      la_pending   <= 1'b0;
      la_value_q   <= '0;
    end else begin
      state <= state_nxt;

      if (wr_ctrl) begin
        ctrl_en      <= wbs_dat_i[0];
        ctrl_oneshot <= wbs_dat_i[1];
        ctrl_irq_en  <= wbs_dat_i[2];
      end
      if (wr_req && reg_sel == A_LOAD)
        load_val <= BITS'(merge_bytes(32'(load_val), wbs_dat_i, byte_mask));
      if (wr_req && reg_sel == A_CMP)
        cmp_val <= BITS'(merge_bytes(32'(cmp_val), wbs_dat_i, byte_mask));

      if (wb_load)      count <= load_val;
      else if (la_take) count <= la_load_val;
      else if (tick) begin
        if (!at_cmp)            count <= count + BITS'(1);
        else if (!ctrl_oneshot) count <= load_val;
      end

      // Setting has priority over a same-cycle write-1-to-clear.
      if (tick && at_cmp)
        match_flag <= 1'b1;
      else if (wr_req && reg_sel == A_STATUS && wbs_sel_i[0] && wbs_dat_i[0])
        match_flag <= 1'b0;

      if (wb_load) begin
        if (la_load_i) begin
          la_pending <= 1'b1;
          la_value_q <= la_value_i;
        end
      end else begin
        la_pending <= 1'b0;
      end
    end
  end

`ifdef COUNTER_SEQ_PRESCALER_EN
  logic [7:0] prescale, presc_cnt;

  assign presc_done = (presc_cnt == prescale);

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      prescale  <= 8'd0;
      presc_cnt <= 8'd0;
    end else begin
      if (wr_req && reg_sel == A_PRESC && wbs_sel_i[0])
        prescale <= wbs_dat_i[7:0];
      if (load_any || state_nxt != state || state != ST_RUN || presc_done)
        presc_cnt <= 8'd0;
      else
        presc_cnt <= presc_cnt + 8'd1;
    end
  end
`else
  assign presc_done = 1'b1;
`endif

  always_comb begin
    rd_data = '0;
    case (reg_sel)
      A_CTRL:   rd_data = {29'd0, ctrl_irq_en, ctrl_oneshot, ctrl_en};
      A_LOAD:   rd_data = 32'(load_val);
      A_CMP:    rd_data = 32'(cmp_val);
      A_STATUS: rd_data = {28'd0, state, running_o, match_flag};
      A_COUNT:  rd_data = 32'(count);
`ifdef COUNTER_SEQ_PRESCALER_EN
      A_PRESC:  rd_data = {24'd0, prescale};
`endif
      default:  rd_data = '0;
    endcase
  end

  // Ack rises one cycle after a request and drops the next, giving exactly one ack per access.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
    end else begin
      wbs_ack_o <= wb_req;
      wbs_dat_o <= rd_req ? rd_data : '0;
    end
  end

  assign count_o   = count;
  assign running_o = (state == ST_RUN);
  assign irq_o     = match_flag & ctrl_irq_en;
  assign la_busy_o = la_pending;

endmodule

// File: tb/tb_counter_sequencer.sv
// Directed bench for counter_sequencer: table-driven register access plus hand-written
// sequences for reload, one-shot, LA arbitration, wrap, reset and (optionally) prescaling.
module tb_counter_sequencer;
  localparam int BITS = 16;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            stb, cyc, we;
  logic [3:0]      sel;
  logic [31:0]     dat_w, adr;
  logic            ack;
  logic [31:0]     dat_r;
  logic            la_load;
  logic [BITS-1:0] la_value;
  logic            la_busy;
  logic [BITS-1:0] count_o;
  logic            running;
  logic            irq;

  int tests = 0;
  int fails = 0;

  counter_sequencer #(.BITS(BITS)) dut (
    .wb_clk_i  (clk),
    .wb_rst_ni (rst_n),
    .wbs_stb_i (stb),
    .wbs_cyc_i (cyc),
    .wbs_we_i  (we),
    .wbs_sel_i (sel),
    .wbs_dat_i (dat_w),
    .wbs_adr_i (adr),
    .wbs_ack_o (ack),
    .wbs_dat_o (dat_r),
    .la_load_i (la_load),
    .la_value_i(la_value),
    .la_busy_o (la_busy),
    .count_o   (count_o),
    .running_o (running),
    .irq_o     (irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        wr;
    logic [2:0]  idx;
    logic [31:0] data;
    logic [3:0]  be;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[32];
  int   n_vecs = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add_vec(input string name, input logic wr, input logic [2:0] idx,
                         input logic [31:0] data, input logic [3:0] be, input logic [31:0] exp);
    vecs[n_vecs].name = name;
    vecs[n_vecs].wr   = wr;
    vecs[n_vecs].idx  = idx;
    vecs[n_vecs].data = data;
    vecs[n_vecs].be   = be;
    vecs[n_vecs].exp  = exp;
    n_vecs++;
  endtask

  // Called on a negedge; request is seen at the next posedge, ack sampled on the following negedge.
  task automatic wb_access(input logic wr, input logic [2:0] idx, input logic [31:0] data,
                           input logic [3:0] be, output logic [31:0] rdata);
    cyc = 1'b1; stb = 1'b1; we = wr;
    adr = {27'd0, idx, 2'b00}; dat_w = data; sel = be;
    @(posedge clk);
    @(negedge clk);
    check($sformatf("ack_%0d", idx), {31'd0, ack}, 32'd1);
    rdata = dat_r;
    cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0; dat_w = '0;
    @(negedge clk);
  endtask

  task automatic wb_write(input logic [2:0] idx, input logic [31:0] data, input logic [3:0] be);
    logic [31:0] dummy;
    wb_access(1'b1, idx, data, be, dummy);
  endtask

  task automatic wb_read_check(input string name, input logic [2:0] idx, input logic [31:0] exp);
    logic [31:0] got;
    wb_access(1'b0, idx, 32'd0, 4'h0, got);
    check(name, got, exp);
  endtask

  task automatic wait_count(input logic [BITS-1:0] v, input int budget);
    int n = 0;
    while (count_o !== v && n < budget) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("wait_count_%0h", v), 32'(count_o), 32'(v));
  endtask

  task automatic wait_running(input logic v, input int budget);
    int n = 0;
    while (running !== v && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("wait_running", {31'd0, running}, {31'd0, v});
  endtask

  task automatic wait_irq(input int budget);
    int n = 0;
    while (irq !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("wait_irq", {31'd0, irq}, 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, tests %0d", tests);
    $fatal(1);
  end

  initial begin
    logic [31:0]     got;
    logic [BITS-1:0] exp_cnt[8];
    logic            exp_irq[8];

    rst_n = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0;
    dat_w = '0; adr = '0; la_load = 1'b0; la_value = '0;
    repeat (3) @(negedge clk);
    check("rst_count",   32'(count_o), 32'd0);
    check("rst_running", {31'd0, running}, 32'd0);
    check("rst_irq",     {31'd0, irq}, 32'd0);
    check("rst_ack",     {31'd0, ack}, 32'd0);
    check("rst_la_busy", {31'd0, la_busy}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Register access table: writes honour byte enables, narrow fields zero-extend.
    add_vec("w_load",       1'b1, 3'd1, 32'h0000_1234, 4'hF, 32'h0);
    add_vec("r_load",       1'b0, 3'd1, 32'h0,         4'h0, 32'h0000_1234);
    add_vec("w_load_b1",    1'b1, 3'd1, 32'hFFFF_AB00, 4'h2, 32'h0);
    add_vec("r_load_b1",    1'b0, 3'd1, 32'h0,         4'h0, 32'h0000_AB34);
    add_vec("w_load_b2",    1'b1, 3'd1, 32'h0056_0000, 4'h4, 32'h0);
    add_vec("r_load_b2",    1'b0, 3'd1, 32'h0,         4'h0, 32'h0000_AB34);
    add_vec("w_cmp_b0",     1'b1, 3'd2, 32'hFFFF_00EE, 4'h1, 32'h0);
    add_vec("r_cmp_b0",     1'b0, 3'd2, 32'h0,         4'h0, 32'h0000_00EE);
    add_vec("w_ctrl",       1'b1, 3'd0, 32'h0000_0006, 4'h1, 32'h0);
    add_vec("r_ctrl",       1'b0, 3'd0, 32'h0,         4'h0, 32'h0000_0006);
    add_vec("w_ctrl_nosel", 1'b1, 3'd0, 32'h0000_000F, 4'hE, 32'h0);
    add_vec("r_ctrl_nosel", 1'b0, 3'd0, 32'h0,         4'h0, 32'h0000_0006);
    add_vec("w_count_ro",   1'b1, 3'd4, 32'h0000_1234, 4'hF, 32'h0);
    add_vec("r_count_ro",   1'b0, 3'd4, 32'h0,         4'h0, 32'h0);
    add_vec("w_adr6",       1'b1, 3'd6, 32'hFFFF_FFFF, 4'hF, 32'h0);
    add_vec("r_adr6",       1'b0, 3'd6, 32'h0,         4'h0, 32'h0);
    add_vec("r_adr7",       1'b0, 3'd7, 32'h0,         4'h0, 32'h0);
    add_vec("r_status",     1'b0, 3'd3, 32'h0,         4'h0, 32'h0);
`ifdef COUNTER_SEQ_PRESCALER_EN
    add_vec("w_presc",      1'b1, 3'd5, 32'hFFFF_FF07, 4'hF, 32'h0);
    add_vec("r_presc",      1'b0, 3'd5, 32'h0,         4'h0, 32'h0000_0007);
`else
    add_vec("w_adr5",       1'b1, 3'd5, 32'h0000_00FF, 4'hF, 32'h0);
    add_vec("r_adr5",       1'b0, 3'd5, 32'h0,         4'h0, 32'h0);
`endif
    add_vec("w_ctrl_clr",   1'b1, 3'd0, 32'h0,         4'hF, 32'h0);
    add_vec("r_ctrl_clr",   1'b0, 3'd0, 32'h0,         4'h0, 32'h0);

    for (int i = 0; i < n_vecs; i++) begin
      if (vecs[i].wr) wb_write(vecs[i].idx, vecs[i].data, vecs[i].be);
      else            wb_read_check(vecs[i].name, vecs[i].idx, vecs[i].exp);
    end

`ifdef COUNTER_SEQ_PRESCALER_EN
    wb_write(3'd5, 32'd0, 4'h1);
`endif

    // Auto-reload 5..8 with IRQ; CTRL write takes effect one edge before the first sample.
    wb_write(3'd1, 32'd5, 4'hF);
    wb_write(3'd2, 32'd8, 4'hF);
    wb_write(3'd0, 32'h0D, 4'h1);
    exp_cnt[0] = 16'd6; exp_cnt[1] = 16'd7; exp_cnt[2] = 16'd8;
    exp_cnt[3] = 16'd5; exp_cnt[4] = 16'd6; exp_cnt[5] = 16'd7;
    exp_irq[0] = 1'b0;  exp_irq[1] = 1'b0;  exp_irq[2] = 1'b0;
    exp_irq[3] = 1'b1;  exp_irq[4] = 1'b1;  exp_irq[5] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) @(negedge clk);
      check($sformatf("reload_count_%0d", i), 32'(count_o), 32'(exp_cnt[i]));
      check($sformatf("reload_irq_%0d", i), {31'd0, irq}, {31'd0, exp_irq[i]});
    end
    wb_read_check("reload_status", 3'd3, 32'h7);
    wb_write(3'd3, 32'h1, 4'h1);
    check("w1c_irq", {31'd0, irq}, 32'd0);
    // W1C landing on the match cycle leaves MATCH set.
    wait_count(16'd8, 20);
    wb_write(3'd3, 32'h1, 4'h1);
    check("w1c_vs_set_irq", {31'd0, irq}, 32'd1);
    // EN cleared on the match cycle: MATCH set, reload applied, straight to IDLE.
    wait_count(16'd8, 20);
    wb_write(3'd0, 32'h0, 4'h1);
    check("en_clr_running", {31'd0, running}, 32'd0);
    check("en_clr_count", 32'(count_o), 32'd5);
    wb_read_check("en_clr_status", 3'd3, 32'h1);
    wb_write(3'd3, 32'h1, 4'h1);
    wb_read_check("status_cleared", 3'd3, 32'h0);

    // One-shot: stop at CMP in HOLD, reload restart from HOLD, then back to IDLE.
    wb_write(3'd0, 32'h0B, 4'h1);
    wait_running(1'b0, 30);
    check("oneshot_count", 32'(count_o), 32'd8);
    wb_read_check("oneshot_status", 3'd3, 32'h9);
    wb_write(3'd0, 32'h0B, 4'h1);
    check("hold_restart_count", 32'(count_o), 32'd6);
    check("hold_restart_running", {31'd0, running}, 32'd1);
    wait_running(1'b0, 30);
    check("oneshot2_count", 32'(count_o), 32'd8);
    wb_write(3'd0, 32'h0, 4'h1);
    wb_read_check("hold_to_idle_status", 3'd3, 32'h1);
    check("idle_count_kept", 32'(count_o), 32'd8);
    wb_write(3'd3, 32'h1, 4'h1);

    // LA arbitration: WB load wins, LA value deferred one cycle.
    wb_write(3'd1, 32'h10, 4'hF);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h0; dat_w = 32'h08; sel = 4'h1;
    la_load = 1'b1; la_value = 16'h0020;
    @(posedge clk);
    @(negedge clk);
    check("la_arb_ack", {31'd0, ack}, 32'd1);
    check("la_arb_wb_count", 32'(count_o), 32'h10);
    check("la_arb_busy", {31'd0, la_busy}, 32'd1);
    cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0; la_load = 1'b0;
    @(negedge clk);
    check("la_arb_la_count", 32'(count_o), 32'h20);
    check("la_arb_busy_clr", {31'd0, la_busy}, 32'd0);
    // A second LA request while pending replaces the latched value.
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h0; dat_w = 32'h08; sel = 4'h1;
    la_load = 1'b1; la_value = 16'h0020;
    @(posedge clk);
    @(negedge clk);
    check("la_ovr_wb_count", 32'(count_o), 32'h10);
    check("la_ovr_busy", {31'd0, la_busy}, 32'd1);
    cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0;
    la_value = 16'h0030;
    @(negedge clk);
    check("la_ovr_count", 32'(count_o), 32'h30);
    check("la_ovr_busy_clr", {31'd0, la_busy}, 32'd0);
    la_value = 16'h0044;
    @(negedge clk);
    la_load = 1'b0;
    check("la_direct_count", 32'(count_o), 32'h44);
    check("la_direct_busy", {31'd0, la_busy}, 32'd0);
    @(negedge clk);

    // Wrap FFFF -> 0000 without a flag; MATCH only on 0001.
    wb_write(3'd1, 32'hFFFE, 4'hF);
    wb_write(3'd2, 32'h0001, 4'hF);
    wb_write(3'd0, 32'h0D, 4'h1);
    exp_cnt[0] = 16'hFFFF; exp_cnt[1] = 16'h0000; exp_cnt[2] = 16'h0001; exp_cnt[3] = 16'hFFFE;
    exp_irq[0] = 1'b0;     exp_irq[1] = 1'b0;     exp_irq[2] = 1'b0;     exp_irq[3] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      check($sformatf("wrap_count_%0d", i), 32'(count_o), 32'(exp_cnt[i]));
      check($sformatf("wrap_irq_%0d", i), {31'd0, irq}, {31'd0, exp_irq[i]});
    end
    wb_write(3'd0, 32'h0, 4'h1);
    wb_write(3'd3, 32'h1, 4'h1);

`ifdef COUNTER_SEQ_PRESCALER_EN
    // PRESCALE=3: one advance every four RUN cycles.
    wb_write(3'd5, 32'd3, 4'h1);
    wb_write(3'd1, 32'd0, 4'hF);
    wb_write(3'd2, 32'hFFFF, 4'hF);
    wb_write(3'd0, 32'h09, 4'h1);
    exp_cnt[0] = 16'd0; exp_cnt[1] = 16'd0; exp_cnt[2] = 16'd0; exp_cnt[3] = 16'd1;
    exp_cnt[4] = 16'd1; exp_cnt[5] = 16'd1; exp_cnt[6] = 16'd1; exp_cnt[7] = 16'd2;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge clk);
      check($sformatf("presc_count_%0d", i), 32'(count_o), 32'(exp_cnt[i]));
    end
    wb_write(3'd0, 32'h0, 4'h1);
`endif

    // Asynchronous reset mid-RUN with IRQ raised and an ack in flight.
    wb_write(3'd1, 32'h30, 4'hF);
    wb_write(3'd2, 32'h31, 4'hF);
    wb_write(3'd0, 32'h0D, 4'h1);
    wait_irq(60);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'hC; sel = 4'h0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_count",   32'(count_o), 32'd0);
    check("arst_irq",     {31'd0, irq}, 32'd0);
    check("arst_running", {31'd0, running}, 32'd0);
    check("arst_ack",     {31'd0, ack}, 32'd0);
    check("arst_dat",     dat_r, 32'd0);
    cyc = 1'b0; stb = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      wb_read_check($sformatf("post_rst_reg%0d", i), 3'(i), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
